// File: rtl/display_scan.sv
// Four-digit multiplexed HH:MM display scanner: slot prescaler, digit index,
// frame-synchronous shadow update, leading-zero and per-digit blink blanking.
module display_scan #(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic       load,
    input  logic [3:0] blink_mask,
    output logic [1:0] inrg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       frame
);

    localparam logic [19:0] CNT_LAST  = 20'(DIV - 1);
    localparam logic [9:0]  FCNT_LAST = 10'(BLINK_FRAMES - 1);

    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  inrg_q, inrg_d;
    logic        frame_q, frame_d;
    logic        pend_flag_q, pend_flag_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] shadow_q, shadow_d;
    logic [9:0]  fcnt_q, fcnt_d;
    logic        phase_q, phase_d;
    logic        tick, wrap;
    logic [3:0]  nib;

    always_comb begin
        cnt_d       = cnt_q;
        inrg_d      = inrg_q;
        pend_flag_d = pend_flag_q;
        pend_d      = pend_q;
        shadow_d    = shadow_q;
        fcnt_d      = fcnt_q;
        phase_d     = phase_q;

        tick    = (cnt_q == CNT_LAST) && en;
        wrap    = tick && (inrg_q == 2'd3);
        frame_d = wrap;

        if (en) begin
            cnt_d = tick ? 20'd0 : cnt_q + 20'd1;
        end
        if (tick) begin
            inrg_d = inrg_q + 2'd1;
        end

        // A load in the wrap cycle stays pending and is shown one frame later.
        if (wrap) begin
            if (pend_flag_q) begin
                shadow_d = pend_q;
            end
            pend_flag_d = 1'b0;
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = 10'd0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 10'd1;
            end
        end
        if (load) begin
            pend_d      = {hh, mm};
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        case (inrg_q)
            2'd0:    nib = shadow_q[15:12];
            2'd1:    nib = shadow_q[11:8];
            2'd2:    nib = shadow_q[7:4];
            default: nib = shadow_q[3:0];
        endcase
        blank = (nib > 4'd9)
              || (BLANK_LZ && (inrg_q == 2'd0) && (shadow_q[15:12] == 4'd0))
              || (phase_q && blink_mask[inrg_q]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= 20'd0;
            inrg_q      <= 2'd0;
            frame_q     <= 1'b0;
            pend_flag_q <= 1'b0;
            pend_q      <= 16'd0;
            shadow_q    <= 16'd0;
            fcnt_q      <= 10'd0;
            phase_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            inrg_q      <= inrg_d;
            frame_q     <= frame_d;
            pend_flag_q <= pend_flag_d;
            pend_q      <= pend_d;
            shadow_q    <= shadow_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
        end
    end

    assign inrg  = inrg_q;
    assign digit = nib;
    assign frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two parameterisations share stimulus; outputs are
// compared every cycle against a frame-arithmetic model of the scanner.
module tb_display_scan;

    localparam int DIV_A = 4;
    localparam int BF_A  = 2;
    localparam bit LZ_A  = 1'b1;
    localparam int DIV_B = 3;
    localparam int BF_B  = 1;
    localparam bit LZ_B  = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] hh = 8'h00;
    logic [7:0] mm = 8'h00;
    logic [3:0] blink_mask = 4'h0;

    logic [1:0] inrg_a, inrg_b;
    logic [3:0] digit_a, digit_b;
    logic       blank_a, blank_b, frame_a, frame_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    display_scan #(.DIV(DIV_A), .BLINK_FRAMES(BF_A), .BLANK_LZ(LZ_A)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .hh(hh), .mm(mm), .load(load),
        .blink_mask(blink_mask), .inrg(inrg_a), .digit(digit_a),
        .blank(blank_a), .frame(frame_a)
    );

    display_scan #(.DIV(DIV_B), .BLINK_FRAMES(BF_B), .BLANK_LZ(LZ_B)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .hh(hh), .mm(mm), .load(load),
        .blink_mask(blink_mask), .inrg(inrg_b), .digit(digit_b),
        .blank(blank_b), .frame(frame_b)
    );

    // Model: n = enabled clocks since reset; a load becomes visible at the
    // start of the frame after the one in which its clock edge lands.
    typedef struct {
        int          inst;
        logic [15:0] d;
        int          eff;
    } pend_t;

    pend_t       pq[$];
    int          n = 0;
    logic [15:0] shadow_m[2];
    bit          jw[2];

    function automatic int divof(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int bfof(input int i);
        return (i == 0) ? BF_A : BF_B;
    endfunction

    function automatic bit lzof(input int i);
        return (i == 0) ? LZ_A : LZ_B;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, exp_v, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        pq.delete();
        for (int i = 0; i < 2; i++) begin
            shadow_m[i] = 16'h0000;
            jw[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic e, input logic r, input logic ld,
                              input logic [15:0] d);
        pend_t keep[$];
        if (!r) begin
            model_reset();
        end else begin
            if (ld) begin
                for (int i = 0; i < 2; i++) begin
                    pq.push_back('{i, d, (n + int'(e)) / (4 * divof(i)) + 1});
                end
            end
            if (e) n++;
            for (int i = 0; i < 2; i++) begin
                jw[i] = e && (n % (4 * divof(i)) == 0);
            end
            keep = {};
            foreach (pq[k]) begin
                if (pq[k].eff <= n / (4 * divof(pq[k].inst))) begin
                    shadow_m[pq[k].inst] = pq[k].d;
                end else begin
                    keep.push_back(pq[k]);
                end
            end
            pq = keep;
        end
    endtask

    task automatic expect_out(input int i, output logic [1:0] ei, output logic [3:0] ed,
                              output logic eb, output logic ef);
        int slot, frm;
        bit ph;
        slot = n / divof(i);
        frm  = n / (4 * divof(i));
        ei   = 2'(slot % 4);
        ed   = 4'((shadow_m[i] >> (4 * (3 - int'(ei)))) & 16'h000F);
        ph   = ((frm / bfof(i)) % 2) == 1;
        eb   = (ed > 4'd9) || (lzof(i) && ei == 2'd0 && shadow_m[i][15:12] == 4'd0)
             || (ph && blink_mask[ei]);
        ef   = jw[i];
    endtask

    task automatic check_all();
        logic [1:0] ei;
        logic [3:0] ed;
        logic       eb, ef;
        expect_out(0, ei, ed, eb, ef);
        chk("a_inrg", {2'b00, inrg_a}, {2'b00, ei});
        chk("a_digit", digit_a, ed);
        chk("a_blank", {3'b000, blank_a}, {3'b000, eb});
        chk("a_frame", {3'b000, frame_a}, {3'b000, ef});
        expect_out(1, ei, ed, eb, ef);
        chk("b_inrg", {2'b00, inrg_b}, {2'b00, ei});
        chk("b_digit", digit_b, ed);
        chk("b_blank", {3'b000, blank_b}, {3'b000, eb});
        chk("b_frame", {3'b000, frame_b}, {3'b000, ef});
    endtask

    task automatic cyc(input logic e, input logic r, input logic ld,
                       input logic [7:0] h, input logic [7:0] m, input logic [3:0] bm);
        @(negedge clk);
        check_all();
        en = e; rst_n = r; load = ld; hh = h; mm = m; blink_mask = bm;
        model_step(e, r, ld, {h, m});
    endtask

    task automatic run(input int cycles, input logic e, input logic [3:0] bm);
        for (int k = 0; k < cycles; k++) cyc(e, 1'b1, 1'b0, hh, mm, bm);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_digit_a", digit_a, 4'h0);
        chk("rst_blank_a", {3'b000, blank_a}, 4'h1);
        chk("rst_blank_b", {3'b000, blank_b}, 4'h0);
        chk("rst_frame_a", {3'b000, frame_a}, 4'h0);

        // Scan timing from reset, then a mid-frame load at index 1.
        run(20, 1'b1, 4'h0);
        run(1, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 4'h0);
        run(40, 1'b1, 4'h0);

        // Leading-zero hours, then blinking of the hour digits.
        cyc(1'b1, 1'b1, 1'b1, 8'h09, 8'h59, 4'h0);
        run(40, 1'b1, 4'h0);
        run(100, 1'b1, 4'b0011);

        // Last write wins; a non-BCD minute digit goes dark.
        cyc(1'b1, 1'b1, 1'b1, 8'h11, 8'h11, 4'h0);
        run(2, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h22, 8'h22, 4'h0);
        run(20, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h22, 8'h3A, 4'h0);
        run(20, 1'b1, 4'h0);

        // Freeze mid-slot with a load pending, then reset discards it.
        run(5, 1'b1, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 8'h55, 8'h55, 4'h0);
        run(10, 1'b0, 4'hF);
        cyc(1'b1, 1'b0, 1'b0, 8'h55, 8'h55, 4'h0);
        run(40, 1'b1, 4'h0);
        chk("post_rst_digit_a", digit_a, 4'h0);

        // Random traffic, including loads on wrap cycles and en toggling.
        for (int k = 0; k < 4000; k++) begin
            cyc(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                8'($urandom), 8'($urandom), 4'($urandom));
        end
        @(negedge clk);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 125, SHALL set the frames per blink half-period; legal range 1..1023.
REQ-003 Parameter BLANK_LZ, default 1, SHALL enable blanking of a leading zero in the hours-tens digit.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  scan enable; 0 freezes the prescaler, index and blink phase.
REQ-007 hh  in  8  hours, BCD: [7:4] tens, [3:0] units.
REQ-008 mm  in  8  minutes, BCD: [7:4] tens, [3:0] units.
REQ-009 load  in  1  single-cycle request to take hh/mm into the display shadow.
REQ-010 blink_mask  in  4  per-digit blink enable; bit k applies to index k.
REQ-011 inrg  out  2  current digit index; drives the anode decoder directly (0 = hours tens, 1 = hours units, 2 = minutes tens, 3 = minutes units).
REQ-012 digit  out  4  BCD value of the digit at index inrg.
REQ-013 blank  out  1  1 = current digit dark; the segment stage SHALL force all segments off.
REQ-014 frame  out  1  one-cycle pulse on index wrap 3->0.

Function
REQ-015 Prescaler cnt SHALL count 0..DIV-1 while en=1 and hold while en=0; tick = (cnt==DIV-1) & en.
REQ-016 On tick, cnt SHALL return to 0 and inrg SHALL advance by 1 modulo 4; inrg SHALL change only on tick.
REQ-017 frame SHALL be registered, high for exactly the one cycle in which inrg first holds 0 after a 3->0 wrap, and low at all other times.
REQ-018 load=1 SHALL capture hh/mm into a pending register and set a pending flag; a further load before the frame boundary SHALL overwrite the pending data (last write wins).
REQ-019 The shadow register SHALL take the pending data, and the flag SHALL clear, in the same cycle as the 3->0 wrap; the displayed value SHALL therefore never change mid-frame.
REQ-020 load coinciding with the wrap cycle SHALL be transferred at the next wrap, not the current one.
REQ-021 digit SHALL be the shadow nibble selected by inrg, valid in the same cycle as inrg (combinational from registered state, no extra latency).
REQ-022 blink phase SHALL toggle when a frame counter reaches BLINK_FRAMES-1 at a wrap; the counter SHALL then return to 0.
REQ-023 blank SHALL be 1 if any of the following holds, and 0 otherwise:
  - shadow nibble > 9;
  - BLANK_LZ=1, inrg=0 and hours tens = 0;
  - blink phase = 1 and blink_mask[inrg] = 1.
REQ-024 blink_mask SHALL be sampled live (not shadowed).
REQ-025 en falling mid-slot SHALL freeze cnt, inrg, frame counter and phase; en rising SHALL resume from the frozen cnt.

Reset
REQ-026 rst_n=0 at a clk edge SHALL set cnt=0, inrg=0, frame=0, pending flag=0, pending data=0, shadow=0, frame counter=0, blink phase=0.
REQ-027 During and after reset with shadow=0, outputs SHALL be digit=0 and blank=BLANK_LZ.
REQ-028 Reset mid-slot or mid-frame SHALL discard any pending load.

Verification
REQ-029 DIV=4, en=1 after reset -> inrg advances every 4 clks: 0,1,2,3,0; frame high exactly one clk when inrg returns to 0 (clk 16).
REQ-030 load with hh=8'h12, mm=8'h34 in mid-frame at inrg=1 -> digit stays 0 until the wrap, then the next frame shows digit 1,2,3,4 with blank=0.
REQ-031 hh=8'h09, BLANK_LZ=1 -> index 0 blank=1, index 1 digit=9 blank=0; with BLANK_LZ=0 -> index 0 blank=0, digit=0.
REQ-032 BLINK_FRAMES=2, blink_mask=4'b0011 -> indexes 0-1 dark in frames 2-3, lit in frames 0-1 and 4-5; indexes 2-3 never blanked.
REQ-033 Two loads (8'h11/8'h11, then 8'h22/8'h22) within one frame -> next frame shows 2,2,2,2; mm=8'h3A -> index 3 blank=1.
REQ-034 en=0 for 10 clks mid-slot, then rst_n=0 for one clk -> inrg/cnt frozen during en=0; after reset all state cleared and the pending load lost.
